// File: rtl/write_crc_pkg.sv
// Shared constants and types for the DDR5 write-path CRC generator.
package write_crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Burst-length encodings as driven by the write manager.
  localparam logic [1:0] BL16 = 2'b00;
  localparam logic [1:0] BC8  = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } crc_state_t;

endpackage

// File: rtl/write_crc8_step.sv
// Combinational CRC-8 update over one byte, data bit 0 fed first, MSB-first
// register shift. One instance serves one 4-DQ lane for one clock word.
module write_crc8_step
  import write_crc_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] w_c;

  // Eight serial shift steps unrolled into one combinational cloud.
  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < 8; i++) begin
      w_c = {w_c[6:0], 1'b0} ^ ((w_c[7] ^ i_data[i]) ? CRC8_POLY : 8'h00);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/write_crc_gen.sv
// Write-path CRC generator: one CRC-8 per 4-DQ lane over a BL16 or BC8
// burst, returned as a packed code with a one-cycle valid pulse.
// Optional feature macro WR_CRC_ERR_INJ_EN adds i_crc_err_inject, which
// flips bit 0 of every lane in the loaded code.
module write_crc_gen
  import write_crc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_enable,
  input  logic [1:0]     i_burstlength,
  input  logic           i_crc_enable,
  input  logic [2*N-1:0] i_crc_data,
`ifdef WR_CRC_ERR_INJ_EN
  input  logic           i_crc_err_inject,
`endif
  output logic [2*N-1:0] o_crc_code,
  output logic           o_crc_valid
);

  localparam int L = N / 4;

  crc_state_t     r_state, w_state_next;
  logic [2:0]     r_count, w_count_next;
  logic           r_is_bc8, w_is_bc8_next;
  logic           w_start;      // seed lanes from CRC8_INIT instead of r_crc
  logic           w_update;     // lane registers take the step result
  logic           w_pad;        // feed all-ones instead of i_crc_data
  logic           w_enter_done;
  logic [7:0]     r_crc [L];
  logic [7:0]     w_step [L];
  logic [2*N-1:0] w_crc_flat;
  logic [2*N-1:0] w_inj_mask;
  logic [2*N-1:0] r_crc_code;
  logic           r_crc_valid;

  // Next-state, counter and lane-update control.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_is_bc8_next = r_is_bc8;
    w_start       = 1'b0;
    w_update      = 1'b0;
    w_pad         = 1'b0;
    if (i_enable) begin
      case (r_state)
        IDLE, DONE: begin
          if (i_crc_enable) begin
            w_start       = 1'b1;
            w_update      = 1'b1;
            w_is_bc8_next = (i_burstlength == BC8);
            w_count_next  = 3'd1;
            w_state_next  = ACCUM;
          end else begin
            w_count_next = 3'd0;
            w_state_next = IDLE;
          end
        end
        ACCUM: begin
          if (i_crc_enable) begin
            w_update = 1'b1;
            // Terminal compare on the pre-increment count keeps it in 3 bits.
            if (r_is_bc8 && r_count == 3'd3) begin
              w_count_next = 3'd0;
              w_state_next = PAD;
            end else if (!r_is_bc8 && r_count == 3'd7) begin
              w_count_next = 3'd0;
              w_state_next = DONE;
            end else begin
              w_count_next = r_count + 3'd1;
            end
          end else begin
            // Gap inside a burst: the partial CRC is abandoned.
            w_count_next = 3'd0;
            w_state_next = IDLE;
          end
        end
        PAD: begin
          w_update = 1'b1;
          w_pad    = 1'b1;
          if (r_count == 3'd3) begin
            w_count_next = 3'd0;
            w_state_next = DONE;
          end else begin
            w_count_next = r_count + 3'd1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // DONE is only entered from ACCUM or PAD, so this fires once per burst.
  assign w_enter_done = (w_state_next == DONE) && (r_state != DONE);

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
      logic [7:0] w_lane_data;
      logic [7:0] w_seed;
      // Feed order: even beat DQ4k..4k+3 first, then odd beat.
      assign w_lane_data = w_pad ? 8'hFF
                                 : {i_crc_data[N + 4*gi +: 4], i_crc_data[4*gi +: 4]};
      assign w_seed      = w_start ? CRC8_INIT : r_crc[gi];

      write_crc8_step u_step (
        .i_crc  (w_seed),
        .i_data (w_lane_data),
        .o_crc  (w_step[gi])
      );

      assign w_crc_flat[8*gi +: 8] = w_step[gi];
    end
  endgenerate

`ifdef WR_CRC_ERR_INJ_EN
  assign w_inj_mask = {L{8'h01}} & {(2*N){i_crc_err_inject}};
`else
  assign w_inj_mask = '0;
`endif

  // Lane CRC registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < L; k++) r_crc[k] <= CRC8_INIT;
    end else if (w_update) begin
      for (int k = 0; k < L; k++) r_crc[k] <= w_step[k];
    end
  end

  // FSM state, counter and registered result; the code is captured on the
  // edge that enters DONE so it is already new during the valid cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_count     <= 3'd0;
      r_is_bc8    <= 1'b0;
      r_crc_code  <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_is_bc8    <= w_is_bc8_next;
      r_crc_valid <= w_enter_done;
      if (w_enter_done) r_crc_code <= w_crc_flat ^ w_inj_mask;
    end
  end

  assign o_crc_code  = r_crc_code;
  assign o_crc_valid = r_crc_valid;

endmodule

// File: tb/tb_write_crc_gen.sv
// Scoreboard bench for write_crc_gen (two lanes). Expected codes come from a
// polynomial-division model of each lane's 64-bit message.
module tb_write_crc_gen;

  localparam int N = 8;
  localparam int L = N / 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_enable = 1'b0;
  logic [1:0]   i_burstlength = 2'b00;
  logic         i_crc_enable = 1'b0;
  logic [W-1:0] i_crc_data = '0;
  logic         r_inj = 1'b0;
  logic [W-1:0] o_crc_code;
  logic         o_crc_valid;

  write_crc_gen #(.N(N)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_burstlength    (i_burstlength),
    .i_crc_enable     (i_crc_enable),
    .i_crc_data       (i_crc_data),
`ifdef WR_CRC_ERR_INJ_EN
    .i_crc_err_inject (r_inj),
`endif
    .o_crc_code       (o_crc_code),
    .o_crc_valid      (o_crc_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] code;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_assert = 0;
  int           n_fail = 0;
  logic [W-1:0] last_code = '0;
  bit           mon_en = 1'b0;

  // Lane k message: 64 bits, first-fed bit at the top. CRC with init 0 and
  // no final XOR is the remainder of msg * x^8 divided by 0x107.
  function automatic logic [W-1:0] model_code(input logic [W-1:0] w [8], input bit bc8);
    logic [W-1:0] code;
    logic [W-1:0] word;
    logic [63:0]  msg;
    logic [71:0]  v;
    int           pos;
    code = '0;
    for (int k = 0; k < L; k++) begin
      pos = 63;
      msg = '0;
      for (int wi = 0; wi < 8; wi++) begin
        word = (bc8 && wi >= 4) ? {W{1'b1}} : w[wi];
        for (int beat = 0; beat < 2; beat++)
          for (int dq = 0; dq < 4; dq++) begin
            msg[pos] = word[beat*N + 4*k + dq];
            pos--;
          end
      end
      v = {msg, 8'h00};
      for (int i = 71; i >= 8; i--)
        if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      code[8*k +: 8] = v[7:0];
    end
    return code;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_enable     = 1'b1;
    i_crc_enable = 1'b0;
    i_crc_data   = W'($urandom);
    repeat (n) tick();
  endtask

  // Drives one complete burst; the result is due the cycle after the last
  // lane update (last data word for BL16, last pad cycle for BC8).
  task automatic send_burst(input logic [W-1:0] w [8], input logic [1:0] bl,
                            input int freeze_pct);
    bit           bc8;
    int           nwords;
    int           t;
    exp_t         e;
    logic [W-1:0] mask;
    bc8    = (bl == 2'b01);
    nwords = bc8 ? 4 : 8;
    t      = 0;
    for (int i = 0; i < nwords; i++) begin
      if (i > 0 && $urandom_range(99) < freeze_pct) begin
        repeat ($urandom_range(2, 1)) begin
          i_enable     = 1'b0;
          i_crc_enable = 1'($urandom_range(1));
          i_crc_data   = W'($urandom);
          tick();
        end
      end
      i_enable      = 1'b1;
      i_crc_enable  = 1'b1;
      i_burstlength = (i == 0) ? bl : 2'($urandom_range(3));
      i_crc_data    = w[i];
      t = cyc;
      tick();
    end
    if (bc8) begin
      for (int p = 0; p < 4; p++) begin
        i_enable     = 1'b1;
        i_crc_enable = 1'($urandom_range(1));
        i_crc_data   = W'($urandom);
        t = cyc;
        tick();
      end
    end
    mask = '0;
`ifdef WR_CRC_ERR_INJ_EN
    if (r_inj) for (int k = 0; k < L; k++) mask[8*k] = 1'b1;
`endif
    e.code = model_code(w, bc8) ^ mask;
    e.cyc  = t + 1;
    exp_q.push_back(e);
    i_crc_enable = 1'b0;
  endtask

  // Monitor: pops on every pulse; between pulses the code must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_crc_valid) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid cyc=%0d code=%h (no result expected)", cyc, o_crc_code);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (o_crc_code !== e.code) begin
            n_fail++;
            $display("FAIL crc_code cyc=%0d got=%h expected=%h", cyc, o_crc_code, e.code);
          end
          n_assert++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL valid_timing got cycle %0d expected cycle %0d", cyc, e.cyc);
          end
          last_code = e.code;
          $display("result cyc=%0d code=%h expected=%h", cyc, o_crc_code, e.code);
        end
      end else begin
        n_assert++;
        if (o_crc_code !== last_code) begin
          n_fail++;
          $display("FAIL code_hold cyc=%0d got=%h expected=%h", cyc, o_crc_code, last_code);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w [8];
    logic [1:0]   bl;

    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    n_assert++;
    if (o_crc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got=%b expected=0", o_crc_valid);
    end
    n_assert++;
    if (o_crc_code !== '0) begin
      n_fail++;
      $display("FAIL reset_code got=%h expected=0", o_crc_code);
    end
    mon_en = 1'b1;
    idle(2);

    // Zero burst, then single-one in the last-fed and second-to-last bit of
    // lane 0, then last-fed bit of lane 1 only.
    for (int i = 0; i < 8; i++) w[i] = '0;
    send_burst(w, 2'b00, 0); idle(2);
    w[7] = W'(1) << (N + 3);
    send_burst(w, 2'b00, 0); idle(2);
    w[7] = W'(1) << (N + 2);
    send_burst(w, 2'b00, 0); idle(2);
    w[7] = W'(1) << (N + 4 + 3);
    send_burst(w, 2'b00, 0); idle(2);

    // BC8 zeros with random i_crc_enable during the pad cycles.
    for (int i = 0; i < 8; i++) w[i] = '0;
    send_burst(w, 2'b01, 0); idle(3);

    // Abort: enable dropped after word 3.
    for (int i = 0; i < 4; i++) begin
      i_enable = 1'b1; i_crc_enable = 1'b1; i_burstlength = 2'b00;
      i_crc_data = W'($urandom);
      tick();
    end
    idle(12);

    // Reset arriving with word 5, then a full burst.
    for (int i = 0; i < 5; i++) begin
      i_enable = 1'b1; i_crc_enable = 1'b1; i_burstlength = 2'b00;
      i_crc_data = W'($urandom);
      tick();
    end
    i_rst = 1'b1;
    i_crc_data = W'($urandom);
    tick();
    i_rst = 1'b0;
    last_code = '0;
    idle(10);
    for (int i = 0; i < 8; i++) w[i] = W'($urandom);
    send_burst(w, 2'b00, 0); idle(2);

    // Back-to-back: zeros then lane-0 last-bit pattern, no idle between.
    for (int i = 0; i < 8; i++) w[i] = '0;
    send_burst(w, 2'b00, 0);
    w[7] = W'(1) << (N + 3);
    send_burst(w, 2'b00, 0); idle(3);

`ifdef WR_CRC_ERR_INJ_EN
    for (int i = 0; i < 8; i++) w[i] = '0;
    r_inj = 1'b1;
    send_burst(w, 2'b00, 0); idle(3);
    r_inj = 1'b0;
`endif

    // Randomized bursts: all four BL encodings, gaps 0..2, mid-burst freezes.
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < 8; i++) w[i] = W'($urandom);
      bl = 2'($urandom_range(3));
      send_burst(w, bl, 25);
      idle($urandom_range(2));
    end

    idle(12);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_results got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
